snes_pad_responder: RTL
=======================

# snes_pad_responder

Device-side SNES controller emulator: the far end of the latch/pulse/data serial link that the codebase's SNES controller reader drives. Software writes a 16-bit button word through the memory-mapped write bus (`en`/`memwrite`/`writedata`). When an external SNES-style host pulses `latch_in`, the block snapshots that word and shifts it out on `data_out`, one bit per `pulse_in` rising edge, active-low on the wire. It sits beside the rotary encoder and input peripherals in `system` and lets one board act as a game pad for another, or for loopback testing of the reader.

## Interface
Parameters:
- `NUM_BITS`, 16: bits shifted per frame.
- `SYNC_STAGES`, 2: flip-flop stages on `latch_in` and `pulse_in`.
- `TIMEOUT`, 4096: idle clk cycles in SHIFT/DONE before an abort to IDLE.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: memory-map select for the button register.
- `memwrite` in 1: write strobe.
- `writedata` in 16: button word. 1 = pressed.
- `latch_in` in 1: host latch, asynchronous to `clk`.
- `pulse_in` in 1: host clock, asynchronous to `clk`.
- `data_out` out 1: serial data, active-low (0 = pressed).
- `busy` out 1: high in LATCHED or SHIFT.
- `bit_count` out 5: index of the bit currently presented (0..NUM_BITS).
- `frame_done` out 1: one-cycle pulse when the last bit has been consumed.

## Operation
- Button register `btn` (16 bits): loads `writedata` when `en && memwrite` on a clock edge. Reset value 0.
- Bit map (bit 0 shifts first):
  - 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
  - 8 A, 9 X, 10 L, 11 R
  - 12–15 ID bits. The block shifts these as written; software keeps them 0.
- `latch_in` and `pulse_in` each pass through a SYNC_STAGES synchronizer, then a rising/falling edge detector.
- Shadow shift register `sh` (16 bits). `data_out = ~sh[0]` while presenting a bit.
- State machine:
  - IDLE: `data_out` = 1, `bit_count` = 0. Latch rise → LATCHED.
  - LATCHED: `sh <= btn` every cycle. `data_out = ~btn[0]`. Latch fall → SHIFT with `bit_count` = 0.
  - SHIFT: on pulse rise, `sh >>= 1` and `bit_count++`. When `bit_count` reaches NUM_BITS, go to DONE and assert `frame_done` for one cycle.
  - DONE: `data_out` = 0, matching a genuine pad after 16 bits. Further pulses are ignored.
- Latch rise in any state → LATCHED. This restarts the frame and discards any partial frame.
- Watchdog: counter cleared on every pulse edge or latch edge. In SHIFT or DONE, reaching TIMEOUT → IDLE.
- Simultaneous latch fall and register write in the same cycle: the frame uses the previous `btn` value. The write lands for the next frame.
- Writes during SHIFT or DONE never alter the in-flight frame.
- Pulse edges while in LATCHED are ignored.
- Reset mid-frame: immediate return to IDLE with all outputs at their reset values.

## Timing
- Reset values: `data_out`=1, `busy`=0, `bit_count`=0, `frame_done`=0, state IDLE, `btn`=0, `sh`=0, watchdog=0.
- All outputs are registered.
- Pin edge to `data_out` change: SYNC_STAGES+1 clk cycles (3 with the default).
- Host pulse half-period must be ≥ SYNC_STAGES+2 clk cycles. Edges closer than that are not guaranteed to be detected.
- `frame_done` asserts in the same cycle that `bit_count` becomes NUM_BITS.
- A register write is visible in `btn` one cycle after the strobe. In LATCHED it reaches `data_out` one cycle after that.

## Structure
- Shared package `snes_pkg` holds:
  - the button index constants (`SNES_B` … `SNES_R`)
  - `SNES_NUM_BITS` = 16
  - the state enum (IDLE, LATCHED, SHIFT, DONE)
- The reader and the responder both import this package.
- Sub-module `sync_edge`: SYNC_STAGES synchronizer plus edge detector, with outputs `level`, `rise` and `fall`. It is instantiated twice, once for latch and once for pulse.

## Test plan
- Write 0x0081 (B + Right). Latch high 12 cycles, low, then 16 pulses of period 16 cycles. Required: `data_out` sequence 0,1,1,1,1,1,1,0,1,1,1,1,1,1,1,1; `frame_done` once; `data_out` = 0 afterwards.
- Write 0xFFFF during LATCHED, one cycle before latch fall. Required: frame shifts 0xFFFF (all zeros on the wire).
- Write 0x0001 in the same cycle the latch fall is detected, when `btn` was previously 0. Required: frame shifts 0x0000; the next frame shifts 0x0001.
- Latch again after 5 pulses. Required: state LATCHED, `bit_count`=0, the full new frame shifts correctly.
- Latch, then no pulses for TIMEOUT cycles. Required: IDLE, `data_out`=1, `busy`=0.
- Assert `rst` at pulse 8. Required: all outputs at reset values immediately; a following latch/shift frame is correct.

Source files
------------

// File: rtl/snes_pkg.sv
// Shared SNES pad definitions: button bit positions, frame length and the
// link state encoding used by both the controller reader and the responder.
package snes_pkg;

    localparam int SNES_NUM_BITS = 16;

    localparam int SNES_B      = 0;
    localparam int SNES_Y      = 1;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;
    localparam int SNES_X      = 9;
    localparam int SNES_L      = 10;
    localparam int SNES_R      = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCHED = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } snes_state_t;

endpackage

// File: rtl/snes_pad_responder_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, followed by a rise/fall
// detector on the synchronized level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchronizer chain plus one cycle of history for the edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~prev_r;
    assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/snes_pad_responder.sv
// Device side of the SNES pad link: snapshots the software button word on a
// host latch and shifts it out active-low, one bit per host pulse rise.
module snes_pad_responder
    import snes_pkg::*;
#(
    parameter int NUM_BITS    = SNES_NUM_BITS,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        memwrite,
    input  logic [15:0] writedata,
    input  logic        latch_in,
    input  logic        pulse_in,
    output logic        data_out,
    output logic        busy,
    output logic [4:0]  bit_count,
    output logic        frame_done
);

    localparam int                WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [4:0]        LAST_BIT = 5'(NUM_BITS);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT - 1);

    logic [SNES_NUM_BITS-1:0] btn_r;
    logic [SNES_NUM_BITS-1:0] sh_r;
    snes_state_t              state_r;
    logic [WD_W-1:0]          wdog_r;
    logic [4:0]               bit_count_r;
    logic                     data_out_r;
    logic                     busy_r;
    logic                     frame_done_r;

    logic       latch_level_s, latch_rise_s, latch_fall_s;
    logic       pulse_level_s, pulse_rise_s, pulse_fall_s;
    logic       any_edge_s;
    logic       wd_expire_s;
    logic [4:0] next_count_s;
    logic       unused_level_s;

    sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (latch_in),
        .level (latch_level_s),
        .rise  (latch_rise_s),
        .fall  (latch_fall_s)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pulse_in),
        .level (pulse_level_s),
        .rise  (pulse_rise_s),
        .fall  (pulse_fall_s)
    );

    // Only edges drive the FSM; the raw levels are not needed here
    assign unused_level_s = latch_level_s ^ pulse_level_s;

    // Host activity detection and watchdog expiry decode
    always_comb begin
        any_edge_s   = latch_rise_s | latch_fall_s | pulse_rise_s | pulse_fall_s;
        next_count_s = bit_count_r + 5'd1;
        if (((state_r == SHIFT) || (state_r == DONE)) && !any_edge_s && (wdog_r == WD_LIMIT)) begin
            wd_expire_s = 1'b1;
        end else begin
            wd_expire_s = 1'b0;
        end
    end

    // Software-visible button register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_r <= 16'h0000;
        end else if (en && memwrite) begin
            btn_r <= writedata;
        end
    end

    // Watchdog counts idle cycles only while a frame is being clocked out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_r <= '0;
        end else if (any_edge_s || wd_expire_s || (state_r == IDLE) || (state_r == LATCHED)) begin
            wdog_r <= '0;
        end else begin
            wdog_r <= wdog_r + WD_W'(1);
        end
    end

    // Link state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            sh_r         <= 16'h0000;
            bit_count_r  <= 5'd0;
            data_out_r   <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (latch_rise_s) begin
                // A new latch always restarts the frame, whatever was in flight
                state_r     <= LATCHED;
                sh_r        <= btn_r;
                bit_count_r <= 5'd0;
                data_out_r  <= ~btn_r[0];
                busy_r      <= 1'b1;
            end else if (wd_expire_s) begin
                state_r     <= IDLE;
                bit_count_r <= 5'd0;
                data_out_r  <= 1'b1;
                busy_r      <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        bit_count_r <= 5'd0;
                        data_out_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                    LATCHED: begin
                        // btn_r sampled here is the pre-write value when a
                        // write strobe coincides with the latch fall
                        sh_r        <= btn_r;
                        bit_count_r <= 5'd0;
                        data_out_r  <= ~btn_r[0];
                        busy_r      <= 1'b1;
                        if (latch_fall_s) begin
                            state_r <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (pulse_rise_s) begin
                            sh_r        <= {1'b0, sh_r[SNES_NUM_BITS-1:1]};
                            bit_count_r <= next_count_s;
                            if (next_count_s == LAST_BIT) begin
                                state_r      <= DONE;
                                frame_done_r <= 1'b1;
                                data_out_r   <= 1'b0;
                                busy_r       <= 1'b0;
                            end else begin
                                data_out_r <= ~sh_r[1];
                            end
                        end
                    end
                    DONE: begin
                        // A genuine pad holds the line low once all bits are out
                        data_out_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                    default: begin
                        state_r     <= IDLE;
                        bit_count_r <= 5'd0;
                        data_out_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_out_r;
    assign busy       = busy_r;
    assign bit_count  = bit_count_r;
    assign frame_done = frame_done_r;

endmodule
